// File: rtl/pipe_if_fq.sv
// rtl/pipe_if_fq.sv - queued fetch stage: PC, imem port, instruction queue, redirect (IF_PERF_CNT_EN adds perf counters)
module pipe_if_fq #(
  parameter int          ADDR_W   = 10,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_inst,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc8,
  input  logic              redir_valid,
  input  logic [1:0]        pcsource,
  input  logic [31:0]       redir_base,
  input  logic [31:0]       pc_jr,
  input  logic [17:0]       imm18,
  input  logic [27:0]       index28
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_redir
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 2;

  logic [31:0]      pc;
  logic [31:0]      fetch_pc;
  logic             inflight;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   rd_next;
  logic [PTR_W:0]   count_after_pop;
  logic [CW-1:0]    used;
  logic [31:0]      q_inst [DEPTH];
  logic [31:0]      q_pc   [DEPTH];
  logic             pop;
  logic             push;
  logic             redir;
  logic [31:0]      target_raw;
  logic [31:0]      target;
  logic             head_load;
  logic [31:0]      head_inst;
  logic [31:0]      head_pc;

  // Occupancy, handshakes and the credit check that keeps the queue from overflowing
  always_comb begin
    count     = wr_ptr - rd_ptr;
    id_valid  = (count != '0);
    pop       = id_valid & id_ready;
    redir     = redir_valid & (pcsource != 2'b00);
    push      = inflight & ~redir;
    used      = CW'(count) + CW'(inflight) - CW'(pop);
    imem_en   = resetn & ~redir & (used < CW'(DEPTH));
    imem_addr = pc[ADDR_W+1:2];
  end

  // Redirect target selection; low two bits always cleared
  always_comb begin
    target_raw = pc;
    case (pcsource)
      2'b01:   target_raw = pc_jr;
      2'b10:   target_raw = redir_base + {{14{imm18[17]}}, imm18};
      2'b11:   target_raw = {redir_base[31:28], index28};
      default: target_raw = pc;
    endcase
    target = {target_raw[31:2], 2'b00};
  end

  // Pick what the head registers should show after this edge (bypass an arriving word into an empty queue)
  always_comb begin
    rd_next         = rd_ptr + {{PTR_W{1'b0}}, pop};
    count_after_pop = count - {{PTR_W{1'b0}}, pop};
    head_load       = 1'b0;
    head_inst       = id_inst;
    head_pc         = id_pc;
    if (!redir) begin
      if (count_after_pop != '0) begin
        head_load = 1'b1;
        head_inst = q_inst[rd_next[PTR_W-1:0]];
        head_pc   = q_pc[rd_next[PTR_W-1:0]];
      end else if (push) begin
        head_load = 1'b1;
        head_inst = imem_rdata;
        head_pc   = fetch_pc;
      end
    end
  end

  // PC, in-flight tracking and queue pointers; a redirect flushes everything
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc       <= RESET_PC;
      fetch_pc <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= imem_en;
      if (imem_en) fetch_pc <= pc;
      if (redir) begin
        pc     <= target;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (imem_en) pc <= pc + 32'd4;
        if (pop)     rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
        if (push)    wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Queue storage: write the returning instruction with the PC that fetched it
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr[PTR_W-1:0]] <= imem_rdata;
      q_pc[wr_ptr[PTR_W-1:0]]   <= fetch_pc;
    end
  end

  // Registered head outputs; they hold their value while the queue is empty
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_inst <= '0;
      id_pc   <= '0;
      id_pc8  <= 32'd8;
    end else if (head_load) begin
      id_inst <= head_inst;
      id_pc   <= head_pc;
      id_pc8  <= head_pc + 32'd8;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Performance counters: accepted instructions, decode stall cycles, redirects
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_redir <= '0;
    end else begin
      if (pop)                  perf_fetch <= perf_fetch + 32'd1;
      if (id_valid & ~id_ready) perf_stall <= perf_stall + 32'd1;
      if (redir)                perf_redir <= perf_redir + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_if_fq.sv
// tb/tb_pipe_if_fq.sv - scoreboard bench for pipe_if_fq
module tb_pipe_if_fq;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        redir_valid = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] redir_base = '0;
  logic [31:0] pc_jr = '0;
  logic [17:0] imm18 = '0;
  logic [27:0] index28 = '0;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
  logic [31:0] perf_redir;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pops  = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  pipe_if_fq #(.ADDR_W(10), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .resetn(resetn),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc8(id_pc8),
    .redir_valid(redir_valid), .pcsource(pcsource), .redir_base(redir_base),
    .pc_jr(pc_jr), .imm18(imm18), .index28(index28)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch(perf_fetch), .perf_stall(perf_stall), .perf_redir(perf_redir)
`endif
  );

  // Synchronous instruction RAM: content encodes the word address
  always @(posedge clk) if (imem_en) imem_rdata <= {12'h5A0, 10'b0, imem_addr};

  function automatic logic [31:0] inst_for(input logic [31:0] pc);
    return {12'h5A0, 10'b0, pc[11:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int from_c, input int to_c);
    for (int c = from_c; c <= to_c; c++) begin
      @(negedge clk);
      cyc();
    end
  endtask

  // Monitor: every handoff must match the next expected PC
  always @(negedge clk) begin
    if (resetn && id_valid && id_ready) begin
      n_pops++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got pc %h expected none", id_pc);
      end else begin
        exp_pc = sb.pop_front();
        chk("pop_pc", id_pc, exp_pc);
        chk("pop_inst", id_inst, inst_for(exp_pc));
        chk("pop_pc8", id_pc8, exp_pc + 32'd8);
      end
    end
  end

  task automatic do_reset();
    cyc();
    resetn = 1'b0;
    id_ready = 1'b0;
    redir_valid = 1'b0;
    pcsource = 2'b00;
    @(negedge clk);
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_imem_en", {31'b0, imem_en}, 32'd0);
    chk("rst_id_inst", id_inst, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_pc8", id_pc8, 32'd8);
    cyc();
    sb.delete();
    n_pops = 0;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) sb.push_back(base + 32'(i * 4));
  endtask

  initial begin
    // Streaming from reset
    do_reset();
    push_seq(32'h0, 16);
    cyc();
    resetn = 1'b1;
    id_ready = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c < 4) begin
        chk("stream_en", {31'b0, imem_en}, 32'd1);
        chk("stream_addr", {22'b0, imem_addr}, 32'(c));
      end
      if (c < 2) chk("stream_valid_lat", {31'b0, id_valid}, 32'd0);
      if (c == 2) chk("stream_valid_first", {31'b0, id_valid}, 32'd1);
      cyc();
    end
    chk("stream_pops", 32'(n_pops), 32'd11);

    // Backpressure
    do_reset();
    push_seq(32'h0, 12);
    cyc();
    resetn = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      chk("bp_en", {31'b0, imem_en}, (c < 4) ? 32'd1 : 32'd0);
      if (c == 7) begin
        chk("bp_full_valid", {31'b0, id_valid}, 32'd1);
        chk("bp_full_head", id_pc, 32'd0);
      end
      cyc();
    end
    id_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_en", {31'b0, imem_en}, 32'd1);
    cyc();
    run_to(9, 13);
    chk("bp_pops", 32'(n_pops), 32'd6);

    // Negative branch
    do_reset();
    push_seq(32'hF0, 8);
    cyc();
    resetn = 1'b1;
    run_to(0, 2);
    redir_valid = 1'b1;
    pcsource = 2'b10;
    redir_base = 32'h100;
    imm18 = 18'h3FFF0;
    @(negedge clk);
    chk("br_suppress_en", {31'b0, imem_en}, 32'd0);
    cyc();
    redir_valid = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    chk("br_target_addr", {22'b0, imem_addr}, 32'h3C);
    chk("br_flushed", {31'b0, id_valid}, 32'd0);
    cyc();
    run_to(5, 10);
    chk("br_pops", 32'(n_pops), 32'd5);

    // Jump with imem address wrap
    do_reset();
    push_seq(32'hA000_0FFC, 8);
    cyc();
    resetn = 1'b1;
    id_ready = 1'b1;
    run_to(0, 0);
    redir_valid = 1'b1;
    pcsource = 2'b11;
    redir_base = 32'hA000_0040;
    index28 = 28'h000_0FFC;
    @(negedge clk);
    chk("jmp_suppress_en", {31'b0, imem_en}, 32'd0);
    cyc();
    redir_valid = 1'b0;
    @(negedge clk);
    chk("jmp_addr", {22'b0, imem_addr}, 32'h3FF);
    cyc();
    @(negedge clk);
    chk("jmp_addr_wrap", {22'b0, imem_addr}, 32'h0);
    cyc();
    run_to(4, 7);
    chk("jmp_pops", 32'(n_pops), 32'd4);

    // Pop in the redirect cycle
    do_reset();
    sb.push_back(32'h0);
    push_seq(32'h20, 6);
    cyc();
    resetn = 1'b1;
    id_ready = 1'b1;
    run_to(0, 1);
    redir_valid = 1'b1;
    pcsource = 2'b01;
    pc_jr = 32'h23;
    @(negedge clk);
    chk("jr_head_valid", {31'b0, id_valid}, 32'd1);
    cyc();
    redir_valid = 1'b0;
    @(negedge clk);
    chk("jr_addr", {22'b0, imem_addr}, 32'h8);
    cyc();
    @(negedge clk);
    chk("jr_no_stale", {31'b0, id_valid}, 32'd0);
    cyc();
    run_to(5, 7);
    chk("jr_pops", 32'(n_pops), 32'd4);

    // Reset mid-stream
    do_reset();
    cyc();
    resetn = 1'b1;
    run_to(0, 2);
    @(negedge clk);
    chk("mid_half_valid", {31'b0, id_valid}, 32'd1);
    cyc();
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, id_valid}, 32'd0);
    chk("mid_rst_en", {31'b0, imem_en}, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("mid_perf_fetch", perf_fetch, 32'd0);
    chk("mid_perf_stall", perf_stall, 32'd0);
    chk("mid_perf_redir", perf_redir, 32'd0);
`endif
    cyc();
    cyc();
    sb.delete();
    n_pops = 0;
    push_seq(32'h0, 8);
    resetn = 1'b1;
    id_ready = 1'b1;
    @(negedge clk);
    chk("mid_restart_addr", {22'b0, imem_addr}, 32'h0);
    chk("mid_restart_en", {31'b0, imem_en}, 32'd1);
    cyc();
    run_to(1, 3);
    chk("mid_pops", 32'(n_pops), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_if_fq.md
Name: pipe_if_fq

Overview:
- Parametrised successor to the single-cycle fetch stage: owns the PC register and drives a synchronous instruction memory port.
- Buffers fetched instructions in a DEPTH-entry queue so decode can stall without refetching.
- Computes redirect targets for jr, branch and jump, then flushes queued and in-flight fetches on a redirect.
- Sits between the instruction RAM and the decode stage.

Parameters:
- ADDR_W, 10, word-address width of the instruction memory (byte PC bits [ADDR_W+1:2]).
- DEPTH, 4, instruction queue entries; power of 2, minimum 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- imem_en  out  1  fetch request this cycle.
- imem_addr  out  ADDR_W  word address, = pc[ADDR_W+1:2].
- imem_rdata  in  32  instruction; valid the cycle after the matching imem_en.
- id_valid  out  1  queue head valid.
- id_ready  in  1  decode accepts the head this cycle.
- id_inst  out  32  head instruction.
- id_pc  out  32  head PC.
- id_pc8  out  32  id_pc+8 (link value).
- redir_valid  in  1  redirect request.
- pcsource  in  2  00 none, 01 jr, 10 branch, 11 jump.
- redir_base  in  32  PC+4 of the redirecting instruction.
- pc_jr  in  32  jr target.
- imm18  in  18  branch byte offset (already <<2), signed.
- index28  in  28  jump index (already <<2).

Behaviour:
- Reset (async, resetn=0):
  - pc=RESET_PC; queue empty; in-flight flag=0.
  - imem_en=0, id_valid=0, id_inst=0, id_pc=0, id_pc8=8.
  - Reset asserted mid-operation discards all state immediately.
- Issue rule: imem_en=1 when resetn=1 and (count + inflight - pop) < DEPTH, where pop = id_valid & id_ready.
  - The pc advances by 4 on issue, modulo 2^32.
  - imem_addr wraps naturally at 2^ADDR_W words.
- Response: in the cycle after an issue (inflight=1), imem_rdata and the issuing pc are written to the queue tail at the clock edge.
  - The entry is visible on id_* the following cycle.
  - First id_valid appears 2 cycles after the first issue.
  - Sustained throughput is 1 instruction/cycle when id_ready=1.
- Queue: circular buffer, pointers of width log2(DEPTH)+1.
  - Simultaneous push and pop allowed at any occupancy, including full and empty.
  - Push never occurs when full, because the credit rule guarantees it.
- Outputs: id_inst, id_pc and id_pc8 are driven from the head entry, registered.
  - Contents are undefined-free: they hold the last value when id_valid=0.
- Redirect: when redir_valid=1 and pcsource!=00, the target is:
  - 01: pc_jr.
  - 10: redir_base + sign-extend(imm18) (32-bit, wraps).
  - 11: {redir_base[31:28], index28}.
  - Target bits [1:0] are forced to 00.
- Redirect effects at the clock edge:
  - pc <= target.
  - Queue cleared.
  - The in-flight response (if any) is discarded, never pushed.
  - The issue in the redirect cycle is suppressed (imem_en=0).
  - Fetch of the target begins the next cycle.
- When redir_valid=1 and pcsource=00, the redirect is ignored.
- Priority: reset > redirect > pop/push/issue.
  - A pop in the redirect cycle is still a valid handoff; decode asserts the redirect in the cycle it accepts the delay-slot instruction.
  - There is no delay-slot preservation beyond that.
- id_pc8 = id_pc + 8, modulo 2^32.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch [31:0], perf_stall [31:0] and perf_redir [31:0], all reset to 0.
  - perf_fetch increments on each pop.
  - perf_stall increments each cycle with id_valid=1 & id_ready=0.
  - perf_redir increments on each accepted redirect.
  - All counters wrap at 2^32.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset and streaming: release resetn with RESET_PC=0 and id_ready=1 -> imem_addr 0,1,2,... on consecutive cycles; id_valid first high 2 cycles after the first issue; id_pc 0,4,8 on consecutive cycles; id_pc8 = id_pc+8.
- Backpressure: DEPTH=4, id_ready=0 from start -> exactly 4 issues, then imem_en=0, queue full; raise id_ready -> 4 pops in order (pc 0..12), fetching resumes with no loss or duplication.
- Negative branch: redir_valid=1, pcsource=10, redir_base=0x100, imm18=18'h3FFF0 -> next imem_addr word 0x3C (target 0xF0); queued entries and in-flight instruction never appear on id_*.
- Jump wrap: pcsource=11, redir_base=0xA000_0040, index28=0x0000_0FFC -> target 0xA000_0FFC; after issue, pc=0xA000_1000 and imem_addr wraps to 0 with ADDR_W=10.
- Simultaneous pop and redirect: head valid, id_ready=1, redirect jr with pc_jr=0x23 -> head accepted, next id_pc=0x20, no stale entry.
- Reset mid-stream: drop resetn while the queue is half full -> id_valid=0 and imem_en=0 immediately; after release, fetch restarts at RESET_PC. With IF_PERF_CNT_EN, the counters read 0.
